// File: rtl/cic_interp.sv
// N-stage CIC interpolator: combs at the input rate, zero-stuff by R, integrators at clk rate.
// Optional output normalisation by an arithmetic shift when CIC_INTERP_GAIN_NORM_EN is defined.
module cic_interp #(
  parameter int R    = 4,
  parameter int N    = 3,
  parameter int M    = 1,
  parameter int IN_W = 8,
  localparam int W   = IN_W + N * $clog2(R * M)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IN_W-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [W-1:0]    out_data,
  output logic            out_valid,
  output logic            underrun
);

  localparam int            PW   = $clog2(R);
  localparam logic [PW-1:0] LAST = PW'(R - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       phase_q, phase_d;
  logic signed [W-1:0] comb_q, comb_d;
  logic signed [W-1:0] up_q, up_d;
  logic signed [W-1:0] dly_q [N][M];
  logic signed [W-1:0] dly_d [N][M];
  logic signed [W-1:0] integ_q [N];
  logic signed [W-1:0] integ_d [N];
  logic signed [W-1:0] c [N+1];
  logic                out_valid_q, out_valid_d;
  logic                underrun_q, underrun_d;
  logic                last, slot;

  assign last     = (state_q == RUN) && (phase_q == LAST);
  assign in_ready = (state_q == IDLE) || last;
  // In RUN a slot happens every R clocks whether or not a sample is offered.
  assign slot     = (state_q == IDLE) ? in_valid : last;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    comb_d      = comb_q;
    dly_d       = dly_q;
    integ_d     = integ_q;
    out_valid_d = out_valid_q;
    underrun_d  = underrun_q | (last && !in_valid);

    if (state_q == IDLE) begin
      if (in_valid) begin
        state_d = RUN;
        phase_d = '0;
      end
    end else begin
      phase_d = last ? '0 : phase_q + 1'b1;
    end
    if (state_d == RUN) out_valid_d = 1'b1;

    // A missing sample on a RUN slot is treated as zero.
    c[0] = in_valid ? {{(W-IN_W){in_data[IN_W-1]}}, in_data} : '0;
    for (int k = 1; k <= N; k++) c[k] = c[k-1] - dly_q[k-1][M-1];

    if (slot) begin
      comb_d = c[N];
      for (int k = 0; k < N; k++) begin
        dly_d[k][0] = c[k];
        for (int j = 1; j < M; j++) dly_d[k][j] = dly_q[k][j-1];
      end
    end

    up_d = (state_q == RUN && phase_q == '0) ? comb_q : '0;

    if (state_q == RUN) begin
      integ_d[0] = integ_q[0] + up_q;
      for (int k = 1; k < N; k++) integ_d[k] = integ_q[k] + integ_q[k-1];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the delay line and integrators are reset too, so an aborted stream leaves no residue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      comb_q      <= '0;
      up_q        <= '0;
      out_valid_q <= 1'b0;
      underrun_q  <= 1'b0;
      for (int k = 0; k < N; k++) begin
        integ_q[k] <= '0;
        for (int j = 0; j < M; j++) dly_q[k][j] <= '0;
      end
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      comb_q      <= comb_d;
      up_q        <= up_d;
      out_valid_q <= out_valid_d;
      underrun_q  <= underrun_d;
      integ_q     <= integ_d;
      dly_q       <= dly_d;
    end
  end

`ifdef CIC_INTERP_GAIN_NORM_EN
  localparam int G = N * $clog2(R * M) - $clog2(R);
  assign out_data = integ_q[N-1] >>> G;
`else
  assign out_data = integ_q[N-1];
`endif

  assign out_valid = out_valid_q;
  assign underrun  = underrun_q;

endmodule
